// File: rtl/inst_buf_if.sv
// Fetch/decode handshake bundle for the instruction buffer.
// The buffer is the slave; fetch and decode together form the master side.
interface inst_buf_if #(
  parameter int INST_L    = 32,
  parameter int PC_L      = 32,
  parameter int DEPTH_LOG = 3
);
  logic                buf_we;
  logic [INST_L-1:0]   inst_in;
  logic [PC_L-1:0]     pc_in;
  logic                buf_wack;
  logic                buf_f;
  logic                buf_re;
  logic                buf_rack;
  logic [INST_L-1:0]   inst_out;
  logic [PC_L-1:0]     pc_out;
  logic                buf_e;
  logic                purge;
  logic [DEPTH_LOG:0]  count;

  modport master (
    output buf_we, inst_in, pc_in, buf_re, purge,
    input  buf_wack, buf_f, buf_rack, inst_out, pc_out, buf_e, count
  );

  modport slave (
    input  buf_we, inst_in, pc_in, buf_re, purge,
    output buf_wack, buf_f, buf_rack, inst_out, pc_out, buf_e, count
  );
endinterface

// File: rtl/inst_buf.sv
// Circular instruction/PC FIFO between fetch and decode, with four-phase
// write and read handshakes and a synchronous purge for taken branches.
module inst_buf #(
  parameter int INST_L    = 32,
  parameter int PC_L      = 32,
  parameter int DEPTH_LOG = 3
) (
  input  logic        clk,
  input  logic        rst,
  inst_buf_if.slave   bif
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] CNT_FULL = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] CNT_ONE  = (DEPTH_LOG+1)'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);

  typedef struct packed {
    logic [INST_L-1:0] inst;
    logic [PC_L-1:0]   pc;
  } entry_t;

  typedef enum logic {W_IDLE, W_ACK} w_state_t;
  typedef enum logic {R_IDLE, R_ACK} r_state_t;

  w_state_t w_state, w_nxt;
  r_state_t r_state, r_nxt;

  entry_t               mem [DEPTH];
  logic [DEPTH_LOG-1:0] wptr, rptr;
  logic [DEPTH_LOG:0]   cnt, cnt_nxt;
  logic                 full, empty;
  logic                 wr_acc, rd_acc;
  logic [INST_L-1:0]    inst_q;
  logic [PC_L-1:0]      pc_q;

  // Acceptance looks at the registered flags only, so space freed by a read
  // becomes usable one edge later.
  always_comb begin
    w_nxt  = w_state;
    wr_acc = 1'b0;
    case (w_state)
      W_IDLE: if (bif.buf_we && !full && !bif.purge) begin
        wr_acc = 1'b1;
        w_nxt  = W_ACK;
      end
      W_ACK:  if (!bif.buf_we) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_nxt  = r_state;
    rd_acc = 1'b0;
    case (r_state)
      R_IDLE: if (bif.buf_re && !empty && !bif.purge) begin
        rd_acc = 1'b1;
        r_nxt  = R_ACK;
      end
      R_ACK:  if (!bif.buf_re) r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (bif.purge)             cnt_nxt = '0;
    else if (wr_acc && !rd_acc) cnt_nxt = cnt + CNT_ONE;
    else if (rd_acc && !wr_acc) cnt_nxt = cnt - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      inst_q  <= '0;
      pc_q    <= '0;
    end else begin
      w_state <= w_nxt;
      r_state <= r_nxt;
      cnt     <= cnt_nxt;
      full    <= (cnt_nxt == CNT_FULL);
      empty   <= (cnt_nxt == '0);
      if (bif.purge) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_acc) wptr <= wptr + PTR_ONE;
        if (rd_acc) begin
          rptr   <= rptr + PTR_ONE;
          inst_q <= mem[rptr].inst;
          pc_q   <= mem[rptr].pc;
        end
      end
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= '{inst: bif.inst_in, pc: bif.pc_in};
  end

  assign bif.buf_wack = (w_state == W_ACK);
  assign bif.buf_rack = (r_state == R_ACK);
  assign bif.buf_f    = full;
  assign bif.buf_e    = empty;
  assign bif.count    = cnt;
  assign bif.inst_out = inst_q;
  assign bif.pc_out   = pc_q;
endmodule

// File: tb/tb_inst_buf.sv
// Randomized and directed bench for inst_buf against a queue-based model.
module tb_inst_buf;
  localparam int IL = 32;
  localparam int PL = 32;
  localparam int DL = 3;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_buf_if #(.INST_L(IL), .PC_L(PL), .DEPTH_LOG(DL)) bif ();
  inst_buf #(.INST_L(IL), .PC_L(PL), .DEPTH_LOG(DL)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  // Reference model: FIFO contents as a queue plus the handshake levels.
  logic [63:0] q [$];
  bit          m_wack, m_rack, m_f, m_e;
  logic [31:0] m_inst, m_pc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wack = 0; m_rack = 0; m_f = 0; m_e = 1;
    m_inst = '0; m_pc = '0;
  endtask

  task automatic model_step();
    bit wacc, racc;
    logic [63:0] ent;
    wacc = !m_wack && bif.buf_we && !m_f && !bif.purge;
    racc = !m_rack && bif.buf_re && !m_e && !bif.purge;
    if (bif.purge) q.delete();
    else begin
      if (racc) begin
        ent = q.pop_front();
        m_inst = ent[63:32];
        m_pc   = ent[31:0];
      end
      if (wacc) q.push_back({bif.inst_in, bif.pc_in});
    end
    if (wacc) m_wack = 1; else if (!bif.buf_we) m_wack = 0;
    if (racc) m_rack = 1; else if (!bif.buf_re) m_rack = 0;
    m_f = (q.size() == DEPTH);
    m_e = (q.size() == 0);
  endtask

  task automatic compare();
    chk("count", 64'(bif.count), 64'(q.size()));
    chk("buf_wack", 64'(bif.buf_wack), 64'(m_wack));
    chk("buf_rack", 64'(bif.buf_rack), 64'(m_rack));
    chk("buf_f", 64'(bif.buf_f), 64'(m_f));
    chk("buf_e", 64'(bif.buf_e), 64'(m_e));
    chk("inst_out", 64'(bif.inst_out), 64'(m_inst));
    chk("pc_out", 64'(bif.pc_out), 64'(m_pc));
  endtask

  // Every clock: advance the model on the edge, check the DUT just after.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic wait_ack(input bit is_w, input bit val, input string nm);
    int n = 0;
    while (((is_w ? bif.buf_wack : bif.buf_rack) !== val) && n < 40) begin
      tick();
      n++;
    end
    chk(nm, 64'(is_w ? bif.buf_wack : bif.buf_rack), 64'(val));
  endtask

  task automatic do_write(input logic [31:0] inst, input logic [31:0] pc);
    bif.inst_in = inst; bif.pc_in = pc; bif.buf_we = 1'b1;
    wait_ack(1'b1, 1'b1, "wr_ack_timeout");
    bif.buf_we = 1'b0;
    wait_ack(1'b1, 1'b0, "wr_rel_timeout");
  endtask

  task automatic do_read(output logic [31:0] pc);
    bif.buf_re = 1'b1;
    wait_ack(1'b0, 1'b1, "rd_ack_timeout");
    pc = bif.pc_out;
    bif.buf_re = 1'b0;
    wait_ack(1'b0, 1'b0, "rd_rel_timeout");
  endtask

  initial begin
    logic [31:0] p;
    logic [31:0] pcn;
    int wbias, rbias;
    bif.buf_we = 0; bif.buf_re = 0; bif.purge = 0;
    bif.inst_in = '0; bif.pc_in = '0;

    #1 rst = 1'b1;
    model_reset();
    #2;
    chk("rst_e", 64'(bif.buf_e), 64'd1);
    chk("rst_f", 64'(bif.buf_f), 64'd0);
    chk("rst_count", 64'(bif.count), 64'd0);
    chk("rst_wack", 64'(bif.buf_wack), 64'd0);
    chk("rst_rack", 64'(bif.buf_rack), 64'd0);
    chk("rst_inst", 64'(bif.inst_out), 64'd0);
    chk("rst_pc", 64'(bif.pc_out), 64'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Fill, then a ninth write that waits for a read to free space.
    for (int i = 0; i < 8; i++) do_write(32'h13 + i, 32'h1000 + 4 * i);
    chk("fill_count", 64'(bif.count), 64'd8);
    chk("fill_f", 64'(bif.buf_f), 64'd1);
    bif.inst_in = 32'h1b; bif.pc_in = 32'h1020; bif.buf_we = 1'b1;
    repeat (3) tick();
    chk("ninth_noack", 64'(bif.buf_wack), 64'd0);
    bif.buf_re = 1'b1;
    wait_ack(1'b0, 1'b1, "ninth_rd_timeout");
    chk("ninth_still_wait", 64'(bif.buf_wack), 64'd0);
    chk("ninth_cnt7", 64'(bif.count), 64'd7);
    chk("ninth_rd_pc", 64'(bif.pc_out), 64'h1000);
    bif.buf_re = 1'b0;
    tick();
    chk("ninth_ack", 64'(bif.buf_wack), 64'd1);
    chk("ninth_cnt8", 64'(bif.count), 64'd8);
    bif.buf_we = 1'b0;
    wait_ack(1'b1, 1'b0, "ninth_rel_timeout");

    // Drain in order.
    for (int i = 0; i < 8; i++) begin
      do_read(p);
      chk($sformatf("drain_pc%0d", i), 64'(p), 64'(32'h1004 + 4 * i));
    end
    chk("drain_e", 64'(bif.buf_e), 64'd1);

    // Read on empty waits for a write, acked the edge after it lands.
    bif.buf_re = 1'b1;
    repeat (3) tick();
    chk("empty_noack", 64'(bif.buf_rack), 64'd0);
    bif.inst_in = 32'haa; bif.pc_in = 32'h2000; bif.buf_we = 1'b1;
    tick();
    chk("empty_wack", 64'(bif.buf_wack), 64'd1);
    chk("empty_rack_late", 64'(bif.buf_rack), 64'd0);
    bif.buf_we = 1'b0;
    tick();
    chk("empty_rack", 64'(bif.buf_rack), 64'd1);
    chk("empty_pc", 64'(bif.pc_out), 64'h2000);
    bif.buf_re = 1'b0;
    wait_ack(1'b0, 1'b0, "empty_rel_timeout");

    // Interleaved pairs wrap the pointers.
    for (int i = 0; i < 20; i++) begin
      do_write(32'h100 + i, 32'h3000 + 4 * i);
      do_read(p);
      chk($sformatf("pair_pc%0d", i), 64'(p), 64'(32'h3000 + 4 * i));
    end

    // Simultaneous write and read at count 3.
    for (int i = 0; i < 3; i++) do_write(32'h40 + i, 32'h4000 + 4 * i);
    bif.inst_in = 32'h43; bif.pc_in = 32'h400c;
    bif.buf_we = 1'b1; bif.buf_re = 1'b1;
    tick();
    chk("both_wack", 64'(bif.buf_wack), 64'd1);
    chk("both_rack", 64'(bif.buf_rack), 64'd1);
    chk("both_count", 64'(bif.count), 64'd3);
    chk("both_pc", 64'(bif.pc_out), 64'h4000);
    bif.buf_we = 1'b0; bif.buf_re = 1'b0;
    wait_ack(1'b1, 1'b0, "both_wrel_timeout");
    wait_ack(1'b0, 1'b0, "both_rrel_timeout");

    // Purge at count 5 with a write pending.
    do_write(32'h44, 32'h4010);
    do_write(32'h45, 32'h4014);
    chk("pre_purge_count", 64'(bif.count), 64'd5);
    bif.inst_in = 32'h50; bif.pc_in = 32'h5000;
    bif.buf_we = 1'b1; bif.purge = 1'b1;
    tick();
    chk("purge_count", 64'(bif.count), 64'd0);
    chk("purge_e", 64'(bif.buf_e), 64'd1);
    chk("purge_noack", 64'(bif.buf_wack), 64'd0);
    chk("purge_pc_hold", 64'(bif.pc_out), 64'h4000);
    bif.purge = 1'b0;
    tick();
    chk("post_purge_wack", 64'(bif.buf_wack), 64'd1);
    chk("post_purge_count", 64'(bif.count), 64'd1);
    bif.buf_we = 1'b0;
    wait_ack(1'b1, 1'b0, "purge_rel_timeout");
    do_read(p);
    chk("post_purge_pc", 64'(p), 64'h5000);

    // Reset mid-handshake drops the ack at once.
    bif.inst_in = 32'h60; bif.pc_in = 32'h6000; bif.buf_we = 1'b1;
    tick();
    chk("mid_wack", 64'(bif.buf_wack), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wack", 64'(bif.buf_wack), 64'd0);
    chk("mid_rst_count", 64'(bif.count), 64'd0);
    chk("mid_rst_pc", 64'(bif.pc_out), 64'd0);
    model_reset();
    bif.buf_we = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();

    // Random traffic with shifting write/read bias and occasional purges.
    pcn = 32'h8000;
    for (int c = 0; c < 3000; c++) begin
      wbias = ((c / 300) % 2 == 0) ? 1 : 3;
      rbias = ((c / 300) % 2 == 0) ? 3 : 1;
      if (bif.buf_we && bif.buf_wack) bif.buf_we = 1'b0;
      else if (!bif.buf_we && !bif.buf_wack && $urandom_range(0, wbias) == 0) begin
        bif.buf_we = 1'b1;
        bif.inst_in = $urandom;
        bif.pc_in = pcn;
        pcn += 4;
      end
      if (bif.buf_re && bif.buf_rack) bif.buf_re = 1'b0;
      else if (!bif.buf_re && !bif.buf_rack && $urandom_range(0, rbias) == 0)
        bif.buf_re = 1'b1;
      bif.purge = ($urandom_range(0, 99) == 0);
      tick();
    end
    bif.buf_we = 1'b0; bif.buf_re = 1'b0; bif.purge = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
